// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: synchronises four request lines, latches them as
// pending bits and runs the irq / ack / eoi handshake in front of a priority encoder.
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] req,
    input  logic [4:1] mask,
    output logic [4:1] x_out,
    input  logic [2:0] pcode,
    output logic       irq,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic [4:1] in_service,
    output logic [2:0] vector,
    output logic       ack_err
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t                    state;
    logic [SYNC_STAGES-1:0][4:1] sync_q;
    logic [4:1]                prev;
    logic [4:1]                pending;
    logic [4:1]                synced;
    logic [4:1]                set_v;
    logic [4:1]                sel;
    logic                      hit;

    assign synced = sync_q[SYNC_STAGES-1];
    assign set_v  = EDGE_MODE ? (synced & ~prev) : synced;
    assign x_out  = pending & mask;

    // Decode pcode to a line select; codes outside 1..4 select nothing.
    always_comb begin
        sel = 4'b0000;
        case (pcode)
            3'd1:    sel = 4'b0001;
            3'd2:    sel = 4'b0010;
            3'd3:    sel = 4'b0100;
            3'd4:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
    end

    assign hit = |(sel & x_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
            prev   <= synced;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            in_service <= '0;
            vector     <= '0;
            irq        <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            ack_err <= 1'b0;
            pending <= pending | set_v;
            case (state)
                IDLE: begin
                    if (|x_out) begin
                        state <= REQ;
                        irq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        if (hit) begin
                            // New set on the same line overrides the clear.
                            pending    <= (pending & ~sel) | set_v;
                            in_service <= sel;
                            vector     <= pcode;
                            irq        <= 1'b0;
                            state      <= SERV;
                        end else begin
                            ack_err <= 1'b1;
                        end
                    end else if (x_out == 4'b0000) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERV: begin
                    if (eoi) begin
                        in_service <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule
